// File: rtl/gol_row_streamer.sv
// gol_row_streamer: snapshots a ROWSxCOLS grid and streams it out row by row on valid/ready.
module gol_row_streamer #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int GEN_W = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [ROWS*COLS-1:0]      grid_in_i,
    input  logic                      grid_valid_i,
    output logic                      grid_ready_o,
    output logic [COLS-1:0]           row_data_o,
    output logic [$clog2(ROWS)-1:0]   row_idx_o,
    output logic                      row_valid_o,
    input  logic                      row_ready_i,
    output logic                      row_first_o,
    output logic                      row_last_o,
    output logic [GEN_W-1:0]          gen_count_o,
    output logic [7:0]                drop_count_o,
    output logic                      busy_o
);
    localparam int IW = $clog2(ROWS);
    localparam logic [IW-1:0] LAST = IW'(ROWS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state_q, state_d;
    logic [ROWS*COLS-1:0]   shadow_q, shadow_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [GEN_W-1:0]       gen_q, gen_d;
    logic [7:0]             drop_q, drop_d;
    logic [COLS-1:0]        row_sel;

    // State and datapath registers; an async reset abandons any frame in flight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            gen_q    <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            gen_q    <= gen_d;
            drop_q   <= drop_d;
        end
    end

    // Next state: capture in IDLE; in SEND advance on transfer and count refused strobes.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        gen_d    = gen_q;
        drop_d   = drop_q;
        if (state_q == IDLE) begin
            if (grid_valid_i) begin
                shadow_d = grid_in_i;
                idx_d    = '0;
                state_d  = SEND;
            end
        end else begin
            if (grid_valid_i && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            if (row_ready_i) begin
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    gen_d   = gen_q + GEN_W'(1);
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
        end
    end

    // Outputs decode registered state only; row 0 sits in the top COLS bits of the snapshot.
    always_comb begin
        row_sel      = shadow_q[COLS*(ROWS-1-int'(idx_q)) +: COLS];
        busy_o       = state_q == SEND;
        grid_ready_o = state_q == IDLE;
        row_valid_o  = busy_o;
        row_data_o   = busy_o ? row_sel : '0;
        row_idx_o    = idx_q;
        row_first_o  = busy_o && idx_q == '0;
        row_last_o   = busy_o && idx_q == LAST;
        gen_count_o  = gen_q;
        drop_count_o = drop_q;
    end
endmodule

// File: tb/tb_gol_row_streamer.sv
// tb_gol_row_streamer: directed self-checking bench for gol_row_streamer (GEN_W=4 to reach wrap).
module tb_gol_row_streamer;
    logic         clk_i = 1'b0;
    logic         reset_i = 1'b1;
    logic [255:0] grid_in_i = '0;
    logic         grid_valid_i = 1'b0;
    logic         row_ready_i = 1'b0;
    logic         grid_ready_o, row_valid_o, row_first_o, row_last_o, busy_o;
    logic [15:0]  row_data_o;
    logic [3:0]   row_idx_o;
    logic [3:0]   gen_count_o;
    logic [7:0]   drop_count_o;

    int           checks = 0;
    int           errors = 0;
    logic [3:0]   exp_gen = '0;
    logic [7:0]   exp_drop = '0;
    logic [15:0]  exp_rows [16];
    logic [255:0] grid;

    gol_row_streamer #(.ROWS(16), .COLS(16), .GEN_W(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .grid_in_i(grid_in_i), .grid_valid_i(grid_valid_i),
        .grid_ready_o(grid_ready_o), .row_data_o(row_data_o), .row_idx_o(row_idx_o),
        .row_valid_o(row_valid_o), .row_ready_i(row_ready_i), .row_first_o(row_first_o),
        .row_last_o(row_last_o), .gen_count_o(gen_count_o), .drop_count_o(drop_count_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_rows(input logic [15:0] base, input logic [15:0] step);
        for (int r = 0; r < 16; r++) begin
            exp_rows[r] = base + step * 16'(r);
            grid[(15-r)*16 +: 16] = exp_rows[r];
        end
    endtask

    task automatic bump_drop();
        exp_drop = (exp_drop == 8'hFF) ? 8'hFF : exp_drop + 8'd1;
    endtask

    task automatic idle_state(input string tag);
        chk({tag, "_ready"}, 32'(grid_ready_o), 1);
        chk({tag, "_valid"}, 32'(row_valid_o), 0);
        chk({tag, "_busy"}, 32'(busy_o), 0);
        chk({tag, "_first"}, 32'(row_first_o), 0);
        chk({tag, "_last"}, 32'(row_last_o), 0);
        chk({tag, "_gen"}, 32'(gen_count_o), 32'(exp_gen));
        chk({tag, "_drop"}, 32'(drop_count_o), 32'(exp_drop));
    endtask

    // mode 0: row_ready always high; mode 1: row_ready toggles 1,0,1,0.
    // drop_at: row index at which a DEAD-pattern grid strobe is pulsed (-1 for none).
    task automatic stream(input int mode, input int drop_at);
        int k = 0;
        int c = 0;
        chk("accept_ready", 32'(grid_ready_o), 1);
        grid_in_i = grid;
        grid_valid_i = 1'b1;
        @(posedge clk_i); #1;
        grid_valid_i = 1'b0;
        while (k < 16 && c < 64) begin
            row_ready_i = (mode == 0) || (c % 2 == 0);
            grid_valid_i = (k == drop_at);
            if (grid_valid_i) grid_in_i = {16{16'hDEAD}};
            chk("row_valid", 32'(row_valid_o), 1);
            chk("row_busy", 32'(busy_o), 1);
            chk("row_gready", 32'(grid_ready_o), 0);
            chk("row_data", 32'(row_data_o), 32'(exp_rows[k]));
            chk("row_idx", 32'(row_idx_o), k);
            chk("row_first", 32'(row_first_o), 32'(k == 0));
            chk("row_last", 32'(row_last_o), 32'(k == 15));
            @(posedge clk_i); #1;
            if (grid_valid_i) bump_drop();
            if (row_ready_i) k++;
            grid_valid_i = 1'b0;
            c++;
        end
        row_ready_i = 1'b0;
        exp_gen = exp_gen + 4'd1;
        chk("frame_len", c, (mode == 0) ? 16 : 31);
        idle_state("frame_end");
    endtask

    initial begin
        // reset held with random inputs
        repeat (4) begin
            grid_in_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            grid_valid_i = 1'($urandom);
            row_ready_i = 1'($urandom);
            @(posedge clk_i); #1;
            idle_state("rst");
            chk("rst_idx", 32'(row_idx_o), 0);
            chk("rst_data", 32'(row_data_o), 0);
        end
        grid_valid_i = 1'b0;
        row_ready_i = 1'b0;
        reset_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        idle_state("post_rst");

        // full-rate frame: row k = 16'h1111*k
        set_rows(16'h0000, 16'h1111);
        stream(0, -1);
        // backpressure
        stream(1, -1);
        // single drop mid-frame, frame content must be unaffected
        stream(0, 5);
        chk("drop_one", 32'(drop_count_o), 1);

        // saturation: 300 refused strobes while stalled
        grid_in_i = grid;
        grid_valid_i = 1'b1;
        @(posedge clk_i); #1;
        repeat (300) begin
            grid_in_i = {16{16'hDEAD}};
            @(posedge clk_i); #1;
            bump_drop();
        end
        grid_valid_i = 1'b0;
        chk("sat_drop", 32'(drop_count_o), 255);
        chk("sat_data", 32'(row_data_o), 32'(exp_rows[0]));
        chk("sat_idx", 32'(row_idx_o), 0);
        row_ready_i = 1'b1;
        repeat (16) @(posedge clk_i);
        #1;
        row_ready_i = 1'b0;
        exp_gen = exp_gen + 4'd1;
        idle_state("sat_end");

        // mid-frame reset after row 7 transfer
        grid_in_i = grid;
        grid_valid_i = 1'b1;
        @(posedge clk_i); #1;
        grid_valid_i = 1'b0;
        row_ready_i = 1'b1;
        repeat (8) @(posedge clk_i);
        #1;
        chk("mid_idx", 32'(row_idx_o), 8);
        chk("mid_gen_before", 32'(gen_count_o), 32'(exp_gen));
        reset_i = 1'b1;
        #1;
        exp_gen = '0;
        exp_drop = '0;
        idle_state("mid_rst");
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        row_ready_i = 1'b0;
        set_rows(16'hC0DE, 16'h0101);
        stream(0, -1);

        // wrap: 16 back-to-back frames, gen goes ...14,15,0,1
        set_rows(16'h8001, 16'h0203);
        for (int f = 0; f < 16; f++) stream(0, -1);
        chk("wrap_gen", 32'(gen_count_o), 1);

        // strobe on the final-row transfer edge is dropped
        stream(0, 15);
        chk("final_drop", 32'(drop_count_o), 1);
        chk("final_idle", 32'(grid_ready_o), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
